// File: rtl/pixel_byte_serializer.sv
// Buffers packed {R,G,B} pixels in a small FIFO and emits them as a B,G,R byte stream
// with valid/ready flow control, per-frame last-byte marking and a frame-done pulse.
module pixel_byte_serializer #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned FRAME_PIXELS = 262144
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [23:0]                       in_pixel_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  output logic [7:0]                        out_byte_o,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic                              out_last_o,
  output logic                              frame_done_o,
  output logic                              overflow_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_o
);

  localparam int unsigned AddrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PixW  = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

  localparam logic [CntW-1:0]  FullCount = CntW'(FIFO_DEPTH);
  localparam logic [AddrW-1:0] LastAddr  = AddrW'(FIFO_DEPTH - 1);
  localparam logic [PixW-1:0]  LastPix   = PixW'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {StIdle, StB, StG, StR} state_e;

  state_e            state_q, state_d;
  logic [23:0]       mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [23:0]       hold_q, hold_d;
  logic [PixW-1:0]   pix_cnt_q, pix_cnt_d;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q, overflow_d;
  logic              full, empty, push, pop;

  always_comb begin
    full  = (count_q == FullCount);
    empty = (count_q == '0);
    // A full FIFO never accepts, even when a pop happens in the same cycle.
    push  = in_valid_i && !full;

    state_d     = state_q;
    pop         = 1'b0;
    out_valid_o = 1'b0;
    out_byte_o  = 8'h00;

    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = StB;
        end
      end
      StB: begin
        out_valid_o = 1'b1;
        out_byte_o  = hold_q[7:0];
        if (out_ready_i) state_d = StG;
      end
      StG: begin
        out_valid_o = 1'b1;
        out_byte_o  = hold_q[15:8];
        if (out_ready_i) state_d = StR;
      end
      StR: begin
        out_valid_o = 1'b1;
        out_byte_o  = hold_q[23:16];
        if (out_ready_i) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = StB;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    out_last_o = (state_q == StR) && (pix_cnt_q == LastPix);

    hold_d = pop ? mem_q[rptr_q] : hold_q;
    wptr_d = push ? ((wptr_q == LastAddr) ? '0 : wptr_q + 1'b1) : wptr_q;
    rptr_d = pop  ? ((rptr_q == LastAddr) ? '0 : rptr_q + 1'b1) : rptr_q;

    count_d = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;

    pix_cnt_d = pix_cnt_q;
    if ((state_q == StR) && out_ready_i) begin
      pix_cnt_d = (pix_cnt_q == LastPix) ? '0 : pix_cnt_q + 1'b1;
    end

    frame_done_d = out_last_o && out_ready_i;
    overflow_d   = overflow_q || (in_valid_i && full);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      hold_q       <= '0;
      pix_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      hold_q       <= hold_d;
      pix_cnt_q    <= pix_cnt_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  // Pixel storage carries no control meaning, so it is left out of reset.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= in_pixel_i;
  end

  assign in_ready_o   = !full;
  assign frame_done_o = frame_done_q;
  assign overflow_o   = overflow_q;
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_pixel_byte_serializer.sv
// Directed and randomized-backpressure checks for pixel_byte_serializer
// (FIFO_DEPTH=4, FRAME_PIXELS=4).
module tb_pixel_byte_serializer;

  localparam int unsigned Depth = 4;
  localparam int unsigned Frame = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] in_pixel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        frame_done;
  logic        overflow;
  logic [2:0]  fifo_count;

  int n_total = 0;
  int n_bad   = 0;
  int s_nbytes, s_ndone, s_cyc;

  always #5 clk = ~clk;

  pixel_byte_serializer #(
    .FIFO_DEPTH  (Depth),
    .FRAME_PIXELS(Frame)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_pixel_i  (in_pixel),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_byte_o  (out_byte),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_last_o  (out_last),
    .frame_done_o(frame_done),
    .overflow_o  (overflow),
    .fifo_count_o(fifo_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [23:0] pix_of(input int i, input bit rnd);
    logic [23:0] p;
    if (rnd) p = 24'($urandom);
    else p = {8'(8'h10 + i), 8'(8'h40 + i), 8'(8'h70 + i)};
    return p;
  endfunction

  // Streams npix pixels from a freshly reset block and checks the byte order, out_last
  // placement, frame_done timing and byte stability under stall.
  task automatic stream(input int npix, input bit rnd);
    logic [23:0] pix_q[$];
    logic [7:0]  exp_q[$];
    logic [23:0] p;
    logic [7:0]  prev_byte = '0;
    bit          prev_stall = 1'b0;
    bit          prev_last_hs = 1'b0;
    int          nbytes = 0;
    int          ndone = 0;
    int          cyc = 0;
    for (int i = 0; i < npix; i++) begin
      p = pix_of(i, rnd);
      pix_q.push_back(p);
      exp_q.push_back(p[7:0]);
      exp_q.push_back(p[15:8]);
      exp_q.push_back(p[23:16]);
    end
    while (nbytes < 3 * npix && cyc < 2000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #0;
      check("frame_done", 32'(frame_done), 32'(prev_last_hs));
      if (frame_done) ndone++;
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_byte", 32'(out_byte), 32'(prev_byte));
      end
      prev_last_hs = out_valid && out_ready && out_last;
      prev_stall   = out_valid && !out_ready;
      prev_byte    = out_byte;
      if (out_valid && out_ready) begin
        nbytes++;
        check("byte", 32'(out_byte), 32'(exp_q.pop_front()));
        check("out_last", 32'(out_last), 32'((nbytes % (3 * Frame)) == 0));
      end
      in_valid = (pix_q.size() > 0) && in_ready;
      if (in_valid) in_pixel = pix_q.pop_front();
      step();
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_done_in_time", 32'(cyc < 2000), 32'd1);
    check("frame_done_tail", 32'(frame_done), 32'(prev_last_hs));
    if (frame_done) ndone++;
    s_nbytes = nbytes;
    s_ndone  = ndone;
    s_cyc    = cyc;
  endtask

  logic [23:0] fill_pix[6];
  logic [7:0]  fill_exp[15];
  int          nvalid, first_gap;

  initial begin
    // Reset state
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_byte", 32'(out_byte), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    do_reset();

    // Single pixel, latency
    in_pixel  = 24'h112233;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("single_k_count", 32'(fifo_count), 32'd1);
    check("single_k_valid", 32'(out_valid), 32'd0);
    step();
    check("single_b", {23'd0, out_valid, out_byte}, 32'h133);
    check("single_k1_count", 32'(fifo_count), 32'd0);
    step();
    check("single_g", {23'd0, out_valid, out_byte}, 32'h122);
    step();
    check("single_r", {23'd0, out_valid, out_byte}, 32'h111);
    step();
    check("single_idle", 32'(out_valid), 32'd0);

    // Backpressure
    do_reset();
    in_pixel = 24'hA1B2C3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {23'd0, out_valid, out_byte}, 32'h1C3);
      step();
    end
    out_ready = 1'b1;
    check("bp_release_b", {23'd0, out_valid, out_byte}, 32'h1C3);
    step();
    check("bp_g", {23'd0, out_valid, out_byte}, 32'h1B2);
    step();
    check("bp_r", {23'd0, out_valid, out_byte}, 32'h1A1);
    step();
    check("bp_idle", 32'(out_valid), 32'd0);

    // Fill and overflow
    do_reset();
    for (int i = 0; i < 6; i++) fill_pix[i] = {8'(8'hD0 + i), 8'(8'hE0 + i), 8'(8'hF0 + i)};
    for (int i = 0; i < 5; i++) begin
      fill_exp[3 * i]     = fill_pix[i][7:0];
      fill_exp[3 * i + 1] = fill_pix[i][15:8];
      fill_exp[3 * i + 2] = fill_pix[i][23:16];
    end
    for (int i = 0; i < 6; i++) begin
      in_pixel = fill_pix[i];
      in_valid = 1'b1;
      if (i == 5) begin
        check("fill_count", 32'(fifo_count), 32'd4);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        check("fill_no_ovf_yet", 32'(overflow), 32'd0);
      end
      step();
    end
    in_valid = 1'b0;
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(fifo_count), 32'd4);
    out_ready = 1'b1;
    nvalid    = 0;
    first_gap = -1;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        if (nvalid < 15) check("fill_byte", 32'(out_byte), 32'(fill_exp[nvalid]));
        nvalid++;
      end else if (first_gap < 0) begin
        first_gap = c;
      end
      step();
    end
    check("fill_nbytes", 32'(nvalid), 32'd15);
    check("fill_no_gap", 32'(first_gap), 32'd15);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-frame: pixel 1 in holding register, pixels 2..4 queued
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_pixel = pix_of(i, 1'b0);
      in_valid = 1'b1;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    check("mid_g_byte", {23'd0, out_valid, out_byte}, 32'h141);
    check("mid_count", 32'(fifo_count), 32'd2);
    check("mid_ovf_before", 32'(overflow), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    step();
    rst_n = 1'b1;
    stream(Frame, 1'b0);
    check("mid_nbytes", 32'(s_nbytes), 32'(3 * Frame));
    check("mid_ndone", 32'(s_ndone), 32'd1);

    // Frame framing: two frames back to back
    do_reset();
    stream(8, 1'b0);
    check("frame_nbytes", 32'(s_nbytes), 32'd24);
    check("frame_ndone", 32'(s_ndone), 32'd2);

    // Random backpressure
    do_reset();
    stream(64, 1'b1);
    check("rand_nbytes", 32'(s_nbytes), 32'd192);
    check("rand_ovf", 32'(overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/pixel_byte_serializer.md
# pixel_byte_serializer

Output-side counterpart of the 24-bit pixel stream used throughout the haze-removal pipeline. Accepts packed BGR pixels ({R,G,B} in bits [23:16],[15:8],[7:0]) from a pipeline stage such as the ALE or recovery stage. Buffers them in a small FIFO and emits them as a byte stream in B, G, R order, which is the BMP pixel-array byte order, with valid/ready flow control. It also tracks frame boundaries so a downstream UART, DMA or file sink can frame the image without its own pixel counter.

## Interface
- FIFO_DEPTH, 4: pixel FIFO entries; power of 2, ≥2.
- FRAME_PIXELS, 262144: pixels per frame (512×512); ≥1.
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_pixel  input  24  pixel: [23:16]=R, [15:8]=G, [7:0]=B.
- in_valid  input  1  in_pixel valid this cycle.
- in_ready  output  1  FIFO not full.
- out_byte  output  8  current output byte.
- out_valid  output  1  out_byte valid.
- out_ready  input  1  downstream accepts out_byte.
- out_last  output  1  out_byte is the R byte of the final pixel of a frame.
- frame_done  output  1  one-cycle pulse after a frame's last byte is transferred.
- overflow  output  1  sticky; a pixel was dropped.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  FIFO occupancy; excludes the holding register.

## Operation
- Reset (rst=0, async): FIFO empty, state IDLE, pixel counter 0. Outputs: out_valid=0, out_byte=0, out_last=0, frame_done=0, overflow=0, fifo_count=0, in_ready=1.
- in_ready = (fifo_count != FIFO_DEPTH), combinational. Upstream producers do not stall.
- Input push: in_valid && in_ready writes in_pixel to the FIFO.
- Input drop: in_valid && !in_ready drops the pixel and sets overflow. overflow clears only on reset.
- Simultaneous push and pop: fifo_count unchanged. A push is never allowed when the FIFO is full, even if a pop occurs in the same cycle.
- Holding register: holds one pixel. Byte FSM states:
  - IDLE: out_valid=0. If the FIFO is not empty, pop into the holding register, go to B.
  - B: out_byte=hold[7:0]. On handshake (out_valid && out_ready) go to G.
  - G: out_byte=hold[15:8]. On handshake go to R.
  - R: out_byte=hold[23:16]. On handshake:
    - FIFO not empty: pop the next pixel, go to B. There is no IDLE bubble.
    - FIFO empty: go to IDLE.
- out_valid=1 in states B, G and R. out_byte and out_last stay stable while out_valid && !out_ready.
- Pixel counter: increments on the R-byte handshake. Wraps to 0 after FRAME_PIXELS-1.
- out_last=1 only in state R while the counter = FRAME_PIXELS-1.
- frame_done=1 in the cycle after the out_last handshake.
- Total buffering is FIFO_DEPTH+1 pixels (FIFO plus the holding register).

## Timing
- Latency, empty block: pixel accepted at edge k → FIFO at k. Pop to holding register at edge k+1, so B is valid after edge k+1. With out_ready=1, G follows after edge k+2 and R after edge k+3.
- Throughput: 1 byte/cycle with out_ready=1, i.e. 1 pixel per 3 cycles. Continuous input at 1 pixel/cycle therefore fills the FIFO.
- fifo_count updates at the clock edge of each push or pop.
- Reset asserted mid-frame: everything clears immediately; partial pixels and frames are discarded. After release, the first accepted pixel is pixel 0 of a new frame.
- FRAME_PIXELS=1: out_last is asserted on every R byte.

## Test plan
- Single pixel: reset, then push 0x112233 at edge k with out_ready=1. Required: bytes 0x33, 0x22, 0x11 after edges k+1, k+2, k+3; out_valid=0 after edge k+4; fifo_count returns to 0.
- Backpressure: push 0xA1B2C3, hold out_ready=0 for 5 cycles after B appears. Required: out_byte stays 0xC3 with out_valid=1. After release, 0xB2 then 0xA1 on consecutive cycles.
- Fill/overflow (FIFO_DEPTH=4): out_ready=0, push 6 pixels on consecutive cycles. Required:
  - Pixel 1 goes to the holding register; pixels 2-5 fill the FIFO (fifo_count=4, in_ready=0).
  - Pixel 6 is dropped and overflow=1.
  - After out_ready=1: exactly 15 bytes in order, with no gap between pixels.
- Frame framing (FRAME_PIXELS=4): stream 8 distinct pixels with out_ready=1. Required:
  - 24 bytes total.
  - out_last only on bytes 12 and 24.
  - frame_done pulses once, one cycle after each of those bytes.
- Random out_ready: stream 64 random pixels with out_ready random at 50%. Required: the byte sequence equals the BGR serialization of the inputs, and out_byte is stable whenever it is stalled.
- Reset mid-operation: assert rst during the G byte of pixel 2 of a frame with 2 pixels queued. Required:
  - Immediately: out_valid=0, fifo_count=0, overflow=0.
  - The next frame's out_last lands on byte 3×FRAME_PIXELS after release.
